// File: rtl/exec_unit_if.sv
// Request and register-file write-back bundle for exec_unit.
// master drives requests; slave is the execution unit.
interface exec_unit_if;
    logic       start;
    logic [2:0] op;
    logic [1:0] dst;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       write_en;
    logic [1:0] write_reg;
    logic [7:0] write_data;
    logic       zero;
    logic       carry;

    modport master (
        output start, op, dst, a, b,
        input  busy, done, write_en, write_reg, write_data, zero, carry
    );

    modport slave (
        input  start, op, dst, a, b,
        output busy, done, write_en, write_reg, write_data, zero, carry
    );
endinterface

// File: rtl/exec_unit.sv
// 8-bit execution unit: single-cycle ALU ops plus iterative shifts and shift-add multiply,
// with a one-cycle register-file write-back and registered zero/carry flags.
module exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    exec_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StExec, StIter, StWb} state_e;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpXor = 3'b011;
    localparam logic [2:0] OpShl = 3'b100;
    localparam logic [2:0] OpShr = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpNop = 3'b111;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] dst_q, dst_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic [3:0] cnt_q, cnt_d;
    logic       zero_q, zero_d;
    logic       carry_q, carry_d;
    logic       carry_new;
    logic       update_flags;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        dst_d        = dst_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        carry_new    = 1'b0;
        update_flags = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StExec;
                    op_d    = bus.op;
                    dst_d   = bus.dst;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end
            end
            StExec: begin
                state_d      = StWb;
                update_flags = 1'b1;
                case (op_q)
                    OpAdd: {carry_new, res_d} = {1'b0, a_q} + {1'b0, b_q};
                    OpSub: begin
                        res_d     = a_q - b_q;
                        carry_new = (a_q < b_q);
                    end
                    OpAnd: res_d = a_q & b_q;
                    OpXor: res_d = a_q ^ b_q;
                    OpShl, OpShr: begin
                        res_d = a_q;
                        cnt_d = {1'b0, b_q[2:0]};
                        // A zero shift count finishes here with the unshifted operand.
                        if (b_q[2:0] != 3'd0) begin
                            state_d      = StIter;
                            update_flags = 1'b0;
                        end
                    end
                    OpMul: begin
                        res_d        = 8'h00;
                        cnt_d        = 4'd8;
                        state_d      = StIter;
                        update_flags = 1'b0;
                    end
                    default: update_flags = 1'b0;
                endcase
            end
            StIter: begin
                cnt_d = cnt_q - 4'd1;
                case (op_q)
                    OpShl: res_d = res_q << 1;
                    OpShr: res_d = res_q >> 1;
                    default: begin
                        // Shift-add multiply: a_q walks left, b_q walks right.
                        if (b_q[0]) res_d = res_q + a_q;
                        a_d = a_q << 1;
                        b_d = b_q >> 1;
                    end
                endcase
                if (cnt_q == 4'd1) begin
                    state_d      = StWb;
                    update_flags = 1'b1;
                end
            end
            StWb: state_d = StIdle;
        endcase

        // Flags are loaded on entry to WB so they are valid alongside write_en.
        if (update_flags) begin
            zero_d  = (res_d == 8'h00);
            carry_d = carry_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            dst_q   <= 2'b00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            cnt_q   <= 4'd0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StWb);
    assign bus.write_en   = (state_q == StWb) && (op_q != OpNop);
    assign bus.write_reg  = dst_q;
    assign bus.write_data = res_q;
    assign bus.zero       = zero_q;
    assign bus.carry      = carry_q;
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 8 bits and register address width at 2 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; asserting it SHALL immediately force the reset state of REQ-020.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  3  operation code; latched with start.
REQ-006 dst  input  2  destination register address; latched with start.
REQ-007 a  input  8  operand A, driven by the register file read_data1; latched with start.
REQ-008 b  input  8  operand B, driven by the register file read_data2; latched with start.
REQ-009 busy  output  1  high in EXEC, ITER and WB.
REQ-010 done  output  1  one-cycle pulse in WB.
REQ-011 write_en  output  1  register-file write strobe.
REQ-012 write_reg  output  2  register-file write address; equals latched dst.
REQ-013 write_data  output  8  register-file write data; equals result register.
REQ-014 zero, carry  output  1 each  registered status flags.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, ITER and WB.
- IDLE with start=1 -> EXEC, latching op, dst, a and b.
- EXEC -> ITER or WB according to REQ-016 and REQ-017.
- ITER -> WB when its counter reaches 0.
- WB -> IDLE unconditionally.
REQ-016 Single-cycle ops SHALL compute in EXEC and then enter WB, truncated to 8 bits:
- op 000: ADD, a+b; carry = bit 8 of the sum.
- op 001: SUB, a-b; carry = 1 if a<b (borrow).
- op 010: AND.
- op 011: XOR.
- op 111: NOP; no write.
REQ-017 Multi-cycle ops SHALL use ITER:
- op 100: SHL by b[2:0], one bit per ITER cycle.
- op 101: SHR, logical, by b[2:0], one bit per ITER cycle.
- op 110: MUL, low 8 bits of a*b, shift-add over exactly 8 ITER cycles.
- A shift count of 0 SHALL go from EXEC directly to WB with the result equal to a.
REQ-018 In WB:
- write_en SHALL be 1 for exactly one cycle (0 for NOP).
- done SHALL be 1 for exactly one cycle, including for NOP.
- zero SHALL be updated to (result==0), and carry updated per REQ-016; carry SHALL be 0 for ops other than ADD and SUB.
- Flags SHALL hold until the next WB; NOP SHALL leave the flags unchanged.
REQ-019 Latency and handshake:
- With start sampled at edge 0, write_en SHALL be high during cycle 2 for single-cycle ops, cycle n+2 for shifts by n, and cycle 10 for MUL.
- start SHALL be ignored whenever busy=1, including during WB; the minimum issue interval is 3 cycles.
- Inputs a, b, op and dst may change freely after the start edge without affecting the operation in flight.

Reset
REQ-020 While rst_n=0:
- state = IDLE.
- busy, done, write_en, zero and carry = 0.
- write_reg = 0 and write_data = 0.
- Internal operand and counter registers = 0.
REQ-021 Reset asserted mid-operation SHALL abort it with no write_en pulse, and no write SHALL be issued after release.
REQ-022 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-023 ADD: a=0xF0, b=0x20, dst=2, start -> write_en high in cycle 2, write_reg=2, write_data=0x10, carry=1, zero=0; done is a one-cycle pulse.
REQ-024 SUB: a=0x05, b=0x05 -> write_data=0x00, zero=1, carry=0. Then a=0x03, b=0x04 -> write_data=0xFF, carry=1.
REQ-025 Shifts:
- SHL a=0x81, b=0x03 -> write_en in cycle 5, write_data=0x08.
- SHR a=0x81, b=0x00 -> write_en in cycle 2, write_data=0x81.
REQ-026 MUL a=0x0D, b=0x13 -> write_en in cycle 10, write_data=0xF7 (247). A start pulsed during cycles 1-10 SHALL be ignored.
REQ-027 Reset and NOP:
- MUL started, then rst_n=0 in cycle 4 -> all outputs 0 immediately and no write_en for 12 cycles after release.
- NOP -> done pulse in cycle 2 with write_en=0 and flags unchanged.
